// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode constants and the slave/master FSM state encoding.
package spi_pkg;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
  localparam logic [1:0] SPI_MODE = {SPI_CPOL, SPI_CPHA};

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  // Pads idle high when the shifter is not driving.
  function automatic logic miso_idle_level();
    return 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a third stage used to detect edges of the
// synchronized level; edges appear two clocks after the pin change.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg <= {3{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[1:0], din};
    end
  end

  assign level = sync_reg[1];
  assign rise  = sync_reg[1] & ~sync_reg[2];
  assign fall  = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave: oversamples the SPI pins, shifts W-bit words in/out and
// exchanges them with a source FIFO (get) and a sink (put).
module spi_slave
  import spi_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] in,
  output logic         get,
  input  logic         empty,
  output logic [W-1:0] out,
  output logic         put,
  input  logic         spi_cs_n,
  input  logic         spi_clock,
  input  logic         spi_mosi,
  output logic         spi_miso,
  output logic         spi_miso_oe
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic sync_unused;

  sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clock (clock), .reset (reset), .din (spi_cs_n),
    .level (cs_level), .rise (cs_rise), .fall (cs_fall)
  );

  sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clock (clock), .reset (reset), .din (spi_clock),
    .level (sclk_level), .rise (sclk_rise), .fall (sclk_fall)
  );

  sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clock (clock), .reset (reset), .din (spi_mosi),
    .level (mosi_level), .rise (mosi_rise), .fall (mosi_fall)
  );

  assign sync_unused = ^{cs_level, sclk_level, mosi_rise, mosi_fall};

  spi_state_e     state_reg;
  logic [W-1:0]   tx_reg;
  logic [W-1:0]   rx_reg;
  logic [W-1:0]   rx_next;
  logic [CW-1:0]  bit_cnt_reg;
  logic           reload_reg;
  logic           get_reg;
  logic           put_reg;
  logic [W-1:0]   out_reg;

  assign rx_next = {rx_reg[W-2:0], mosi_level};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      tx_reg      <= '0;
      rx_reg      <= '0;
      bit_cnt_reg <= '0;
      reload_reg  <= 1'b0;
      get_reg     <= 1'b0;
      put_reg     <= 1'b0;
      out_reg     <= '0;
    end else begin
      get_reg <= 1'b0;
      put_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enable && cs_fall) begin
            state_reg   <= SHIFT;
            bit_cnt_reg <= '0;
            rx_reg      <= '0;
            reload_reg  <= 1'b0;
            if (!empty) begin
              get_reg <= 1'b1;
              tx_reg  <= in;
            end else begin
              tx_reg  <= '1;
            end
          end
        end
        SHIFT: begin
          // Leaving wins over a coincident SPI clock edge, so the final falling
          // edge of a frame never pops a word that would not be sent.
          if (!enable || cs_rise) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            rx_reg      <= '0;
            reload_reg  <= 1'b0;
          end else if (sclk_rise) begin
            rx_reg <= rx_next;
            if (bit_cnt_reg == LAST_BIT) begin
              bit_cnt_reg <= '0;
              out_reg     <= rx_next;
              put_reg     <= 1'b1;
              reload_reg  <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + CW'(1);
            end
          end else if (sclk_fall) begin
            if (reload_reg) begin
              reload_reg <= 1'b0;
              if (!empty) begin
                get_reg <= 1'b1;
                tx_reg  <= in;
              end else begin
                tx_reg  <= '1;
              end
            end else begin
              tx_reg <= {tx_reg[W-2:0], 1'b0};
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign get         = get_reg;
  assign put         = put_reg;
  assign out         = out_reg;
  assign spi_miso_oe = (state_reg == SHIFT);
  assign spi_miso    = spi_miso_oe ? tx_reg[W-1] : miso_idle_level();

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master, a FIFO source model and a
// put scoreboard checked by an independent monitor.
module tb_spi_slave;

  localparam int W    = 8;
  localparam int HALF = 50;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] in;
  logic         get;
  logic         empty;
  logic [W-1:0] out;
  logic         put;
  logic         spi_cs_n = 1'b1;
  logic         spi_clock = 1'b0;
  logic         spi_mosi = 1'b0;
  logic         spi_miso;
  logic         spi_miso_oe;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_rx[$];
  logic [W-1:0] mosi_w[3];
  logic [W-1:0] fifo_data[4];
  int           fifo_len = 0;
  int           fifo_base = 0;
  int           get_cnt = 0;
  int           fifo_idx;

  spi_slave #(.W(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .in          (in),
    .get         (get),
    .empty       (empty),
    .out         (out),
    .put         (put),
    .spi_cs_n    (spi_cs_n),
    .spi_clock   (spi_clock),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe)
  );

  always #5 clock = ~clock;

  // Source FIFO: words already popped are those counted by get_cnt since the load.
  assign fifo_idx = get_cnt - fifo_base;
  assign empty    = (fifo_idx >= fifo_len);
  assign in       = empty ? '0 : fifo_data[fifo_idx & 3];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (get) get_cnt++;
    if (put) begin
      checks++;
      if (exp_rx.size() == 0) begin
        errors++;
        $display("FAIL put_unexpected actual=%0h required=no put", out);
      end else begin
        logic [W-1:0] e;
        e = exp_rx.pop_front();
        if (out !== e) begin
          errors++;
          $display("FAIL put_data actual=%0h required=%0h", out, e);
        end else begin
          $display("put out=%0h", out);
        end
      end
    end
  end

  task automatic load_fifo(input int n, input logic [W-1:0] d0, d1, d2);
    fifo_data[0] = d0;
    fifo_data[1] = d1;
    fifo_data[2] = d2;
    fifo_data[3] = '0;
    fifo_base    = get_cnt;
    fifo_len     = n;
  endtask

  // One cs_n frame of nbits; rst_at >= 0 pulses reset before that bit instead.
  task automatic run_frame(input int nbits, input int rst_at);
    int eff, nwords, exp_gets, g0;
    logic en;
    logic [W-1:0] tx_word, exp_word;
    en       = enable;
    g0       = get_cnt;
    tx_word  = '0;
    eff      = (rst_at >= 0) ? rst_at : nbits;
    nwords   = en ? eff / W : 0;
    exp_gets = 0;
    if (en) begin
      exp_gets = 1 + ((eff > 0) ? (eff - 1) / W : 0);
      if (exp_gets > fifo_len) exp_gets = fifo_len;
    end
    for (int j = 0; j < nwords; j++) exp_rx.push_back(mosi_w[j]);

    spi_cs_n = 1'b0;
    spi_mosi = mosi_w[0][W-1];
    #HALF;
    for (int k = 0; k < nbits; k++) begin
      if (k == rst_at) begin
        reset = 1'b0;
        #1;
        check("rst_get", int'(get), 0);
        check("rst_put", int'(put), 0);
        check("rst_out", int'(out), 0);
        check("rst_miso", int'(spi_miso), 1);
        check("rst_miso_oe", int'(spi_miso_oe), 0);
        spi_cs_n  = 1'b1;
        spi_clock = 1'b0;
        #39;
        reset = 1'b1;
        #20;
        break;
      end
      check("miso_oe", int'(spi_miso_oe), int'(en));
      tx_word   = {tx_word[W-2:0], spi_miso};
      spi_clock = 1'b1;
      #HALF;
      spi_clock = 1'b0;
      if (k == nbits - 1) spi_cs_n = 1'b1;
      else spi_mosi = mosi_w[(k + 1) / W][W - 1 - ((k + 1) % W)];
      if (k % W == W - 1) begin
        exp_word = (en && (k / W) < fifo_len) ? fifo_data[k / W] : '1;
        $display("miso word=%0h expected=%0h", tx_word, exp_word);
        check("miso_word", int'(tx_word), int'(exp_word));
      end
      #HALF;
    end
    spi_cs_n  = 1'b1;
    spi_clock = 1'b0;
    #(4 * HALF);
    check("get_count", get_cnt - g0, exp_gets);
    check("put_count", exp_rx.size(), 0);
    exp_rx.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, mode, nbits;
    #4;
    check("reset_get", int'(get), 0);
    check("reset_put", int'(put), 0);
    check("reset_out", int'(out), 0);
    check("reset_miso", int'(spi_miso), 1);
    check("reset_miso_oe", int'(spi_miso_oe), 0);
    #19 reset = 1'b1;
    #20 enable = 1'b1;
    #20;

    load_fifo(1, 8'hA5, 8'h00, 8'h00);
    mosi_w[0] = 8'h3C;
    run_frame(8, -1);

    load_fifo(2, 8'h12, 8'h34, 8'h00);
    mosi_w[0] = 8'h81; mosi_w[1] = 8'h7E;
    run_frame(16, -1);

    load_fifo(0, 8'h00, 8'h00, 8'h00);
    mosi_w[0] = 8'h55;
    run_frame(8, -1);

    mosi_w[0] = 8'hAA;
    run_frame(5, -1);
    load_fifo(1, 8'h5A, 8'h00, 8'h00);
    mosi_w[0] = 8'hC3;
    run_frame(8, -1);

    load_fifo(1, 8'h66, 8'h00, 8'h00);
    mosi_w[0] = 8'h99;
    run_frame(8, 3);
    load_fifo(1, 8'h77, 8'h00, 8'h00);
    mosi_w[0] = 8'hE1;
    run_frame(8, -1);

    enable = 1'b0;
    load_fifo(1, 8'h44, 8'h00, 8'h00);
    mosi_w[0] = 8'hF0;
    run_frame(8, -1);
    enable = 1'b1;
    #40;

    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(0, 3);
      load_fifo(n, W'($urandom), W'($urandom), W'($urandom));
      for (int j = 0; j < 3; j++) mosi_w[j] = W'($urandom);
      mode  = $urandom_range(0, 3);
      nbits = (mode < 3) ? (mode + 1) * W : $urandom_range(1, 3 * W - 1);
      run_frame(nbits, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter W, default 8, word width in bits (W >= 2).
REQ-002 SHALL have port clock  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  block enable; low forces IDLE and releases the bus.
REQ-005 SHALL have port in  input  W  transmit word from the source FIFO.
REQ-006 SHALL have port get  output  1  one-cycle pop strobe; `in` is consumed in that cycle.
REQ-007 SHALL have port empty  input  1  source FIFO empty.
REQ-008 SHALL have port out  output  W  received word, valid while put is high.
REQ-009 SHALL have port put  output  1  one-cycle push strobe for the received word.
REQ-010 SHALL have port spi_cs_n  input  1  chip select from the master, active low.
REQ-011 SHALL have port spi_clock  input  1  SPI clock from the master, mode 0 (CPOL=0, CPHA=0).
REQ-012 SHALL have port spi_mosi  input  1  serial data from the master.
REQ-013 SHALL have port spi_miso  output  1  serial data to the master, MSB first.
REQ-014 SHALL have port spi_miso_oe  output  1  MISO output enable for the pad tristate.

Function
REQ-015 SHALL pass spi_cs_n, spi_clock and spi_mosi through 2-flop synchronizers, then detect edges against a third registered stage.
REQ-016 SHALL have a detection latency of exactly 3 clock edges from a pin change to the cycle acting on it; spi_clock SHALL be at most clock/8.
REQ-017 SHALL implement states IDLE and SHIFT.
REQ-018 IDLE -> SHIFT SHALL occur on a detected cs_n falling edge while enable is high.
REQ-019 SHIFT -> IDLE SHALL occur on a detected cs_n rising edge or when enable goes low.
REQ-020 On entry to SHIFT and on each word reload: if empty=0, SHALL assert get for one cycle and load `in` into the TX shift register.
REQ-021 On that load, if empty=1, SHALL load all-ones and keep get low (underrun filler).
REQ-022 spi_miso SHALL present the TX register MSB, so the first bit is valid before the first rising spi_clock edge.
REQ-023 On each detected spi_clock rising edge in SHIFT, SHALL shift the synchronized mosi into the RX register LSB and increment a bit counter modulo W.
REQ-024 On the W-th rising edge, SHALL place the completed RX word on `out` (including the bit just sampled) and assert put for exactly that one cycle.
REQ-025 On each detected spi_clock falling edge in SHIFT, SHALL shift the TX register left by one.
REQ-026 After a W-th rising edge, the next falling edge SHALL reload the TX register per REQ-020/021 instead of shifting.
REQ-027 spi_miso_oe SHALL be high exactly in SHIFT; spi_miso SHALL be 1 when spi_miso_oe is low.
REQ-028 A cs_n rise or enable drop mid-word SHALL discard the partial RX word with no put, and reset the bit counter to 0.
REQ-029 Coincident put and get (word boundary) SHALL both be honoured; they occur in different cycles per REQ-024/026.
REQ-030 `out` SHALL hold its last value between put strobes.
REQ-031 spi_clock edges seen in IDLE SHALL be ignored.

Reset
REQ-032 While reset is low, SHALL force: state IDLE, get=0, put=0, out=0, spi_miso=1, spi_miso_oe=0, counter=0, shift registers=0, synchronizers=1 for cs_n and 0 for clock and mosi.
REQ-033 Reset assertion SHALL take effect immediately, including mid-word; release SHALL be synchronous to clock through the reset synchronizer owned by the caller.

Structure
REQ-034 The SPI mode constants and state encoding SHALL reside in a shared SPI package, also usable by spi_master variants.
REQ-035 The synchronizer plus edge detector SHALL be one reusable sub-module, sync_edge, instantiated three times.

Verification
REQ-036 W=8, FIFO holds 0xA5, master sends 0x3C -> MISO returns 0xA5; put with out=0x3C; exactly one get.
REQ-037 Two back-to-back words under one cs_n frame, FIFO holds 0x12 and 0x34, master sends 0x81 and 0x7E -> MISO returns 0x12 then 0x34; two puts; gets at entry and at the 8th falling edge.
REQ-038 empty=1, master sends 0x55 -> MISO returns 0xFF; no get; put with out=0x55.
REQ-039 cs_n rises after 5 bits -> no put; next frame sending 0xC3 -> out=0xC3 and correct alignment.
REQ-040 reset pulsed low mid-word -> outputs reach REQ-032 values asynchronously; next frame completes normally.
REQ-041 enable low with an active frame -> spi_miso_oe=0, no get or put.
